// File: rtl/adder_pipe_if.sv
// Operand/result bus for the pipelined add/subtract unit.
// master = upstream/downstream environment, slave = the adder itself.
interface adder_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             of;
  logic             eq;
  logic             cary;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, s, of, eq, cary, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, s, of, eq, cary, zero
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: WIDTH/CHUNK carry-chained segments, one per stage,
// an input capture rank, and a registered output with sum and flags.
module adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);
  localparam int unsigned L = WIDTH / CHUNK;

  // Rank k holds an operation whose chunks 0..k-1 are already summed.
  logic             valid_q [L];
  logic [WIDTH-1:0] opa_q   [L];
  logic [WIDTH-1:0] opb_q   [L];
  logic [WIDTH-1:0] sum_q   [L];
  logic             cy_q    [L];
  logic             eqf_q   [L];

  logic [WIDTH-1:0] nsum [L];
  logic             ncy  [L];
  logic [CHUNK:0]   stage_r;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             of_q;
  logic             eq_q;
  logic             cary_q;
  logic             zero_q;

  logic             adv;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.of        = of_q;
  assign bus.eq        = eq_q;
  assign bus.cary      = cary_q;
  assign bus.zero      = zero_q;

  // Each rank resolves its own chunk using the carry handed down from the previous rank.
  always_comb begin
    stage_r = '0;
    for (int k = 0; k < L; k++) begin
      stage_r = {1'b0, opa_q[k][k*CHUNK +: CHUNK]} + {1'b0, opb_q[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cy_q[k]};
      nsum[k] = sum_q[k];
      nsum[k][k*CHUNK +: CHUNK] = stage_r[CHUNK-1:0];
      ncy[k] = stage_r[CHUNK];
    end
  end

  // Capture, shift and output registers; all hold together when the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        valid_q[k] <= 1'b0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
        sum_q[k]   <= '0;
        cy_q[k]    <= 1'b0;
        eqf_q[k]   <= 1'b0;
      end
      out_valid_q <= 1'b0;
      s_q         <= '0;
      of_q        <= 1'b0;
      eq_q        <= 1'b0;
      cary_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      // Subtract is A + ~B + 1, so cin is overridden by the forced carry.
      valid_q[0] <= bus.in_valid;
      opa_q[0]   <= bus.a;
      opb_q[0]   <= bus.sub ? ~bus.b : bus.b;
      sum_q[0]   <= '0;
      cy_q[0]    <= bus.sub | bus.cin;
      eqf_q[0]   <= (bus.a == bus.b);
      for (int k = 1; k < L; k++) begin
        valid_q[k] <= valid_q[k-1];
        opa_q[k]   <= opa_q[k-1];
        opb_q[k]   <= opb_q[k-1];
        sum_q[k]   <= nsum[k-1];
        cy_q[k]    <= ncy[k-1];
        eqf_q[k]   <= eqf_q[k-1];
      end
      out_valid_q <= valid_q[L-1];
      s_q         <= nsum[L-1];
      cary_q      <= ncy[L-1];
      eq_q        <= eqf_q[L-1];
      of_q        <= (opa_q[L-1][WIDTH-1] == opb_q[L-1][WIDTH-1]) &&
                     (nsum[L-1][WIDTH-1] != opa_q[L-1][WIDTH-1]);
      zero_q      <= (nsum[L-1] == '0);
    end
  end
endmodule
